// File: rtl/cla4_adder_reg.sv
// 4-bit carry-lookahead adder with group propagate/generate outputs.
// The lookahead is combinational and every output is registered, so results appear one cycle later.
module cla4_adder_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] R,
  output logic       Cout,
  output logic       PG,
  output logic       GG
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;
  logic [3:0] sum_next;
  logic       pg_next;
  logic       gg_next;
  logic       cout_next;

  logic [3:0] sum_reg;
  logic       cout_reg;
  logic       pg_reg;
  logic       gg_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign p[gi]        = A[gi] ^ B[gi];
      assign g[gi]        = A[gi] & B[gi];
      assign sum_next[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Each carry is a flat sum of products of bit terms, so no carry waits on another.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);

  // Group terms exclude Cin so a higher lookahead level can combine them.
  assign pg_next   = &p;
  assign gg_next   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign cout_next = gg_next | (pg_next & Cin);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_reg  <= 4'd0;
      cout_reg <= 1'b0;
      pg_reg   <= 1'b0;
      gg_reg   <= 1'b0;
    end else begin
      sum_reg  <= sum_next;
      cout_reg <= cout_next;
      pg_reg   <= pg_next;
      gg_reg   <= gg_next;
    end
  end

  assign R    = sum_reg;
  assign Cout = cout_reg;
  assign PG   = pg_reg;
  assign GG   = gg_reg;

endmodule

// File: tb/tb_cla4_adder_reg.sv
// Bench for cla4_adder_reg: directed vector table, reset corner cases and a full 512-case sweep.
module tb_cla4_adder_reg;

  logic       clk;
  logic       reset;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] R;
  logic       Cout;
  logic       PG;
  logic       GG;

  int passed;
  int total;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] r;
    logic       cout;
    logic       pg;
    logic       gg;
  } vec_t;

  vec_t vecs [10];

  cla4_adder_reg dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .R    (R),
    .Cout (Cout),
    .PG   (PG),
    .GG   (GG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] r, input logic cout,
                         input logic pg, input logic gg);
    chk({tag, " R"}, {1'b0, R}, {1'b0, r});
    chk({tag, " Cout"}, {4'd0, Cout}, {4'd0, cout});
    chk({tag, " PG"}, {4'd0, PG}, {4'd0, pg});
    chk({tag, " GG"}, {4'd0, GG}, {4'd0, gg});
  endtask

  // Drive away from the edge, let one rising edge capture, sample just after it.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
    A   = a;
    B   = b;
    Cin = cin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] full;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       exp_pg;
    logic       exp_gg;

    passed = 0;
    total  = 0;

    vecs[0] = '{4'h2, 4'h3, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'h9, 4'h5, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'h9, 4'h5, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'hA, 4'h7, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};

    // Reset with worst-case inputs: outputs clear before the first clock edge.
    reset = 1'b1;
    A     = 4'hF;
    B     = 4'hF;
    Cin   = 1'b1;
    #3;
    chk_all("reset immediate", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset held", 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin);
      $display("vec %0d: A=%h B=%h Cin=%b -> R=%h Cout=%b PG=%b GG=%b", i,
               vecs[i].a, vecs[i].b, vecs[i].cin, R, Cout, PG, GG);
      chk_all($sformatf("vec%0d", i), vecs[i].r, vecs[i].cout, vecs[i].pg, vecs[i].gg);
    end

    // Mid-stream reset: load a non-zero result, then reset between edges.
    apply(4'hF, 4'hF, 1'b1);
    chk_all("pre-reset", 4'hF, 1'b1, 1'b0, 1'b1);
    A = 4'hA;
    B = 4'h5;
    Cin = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk_all("midstream reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("midstream reset hold", 4'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("first edge after release", 4'h0, 1'b1, 1'b1, 1'b0);

    // Exhaustive sweep; expectations come from plain integer addition.
    for (int i = 0; i < 512; i++) begin
      a   = 4'(i >> 5);
      b   = 4'(i >> 1);
      cin = i[0];
      if (i == 256) begin
        #2;
        reset = 1'b1;
        #1;
        chk_all("sweep reset", 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("sweep reset hold", 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
      end
      apply(a, b, cin);
      full   = 5'(a) + 5'(b) + 5'(cin);
      exp_pg = ((a ^ b) == 4'hF);
      exp_gg = ((5'(a) + 5'(b)) > 5'd15);
      $display("sweep %0d: A=%h B=%h Cin=%b -> R=%h Cout=%b PG=%b GG=%b", i,
               a, b, cin, R, Cout, PG, GG);
      chk_all($sformatf("sweep A=%h B=%h Cin=%b", a, b, cin), full[3:0], full[4], exp_pg, exp_gg);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
